// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction and data ports onto one memory bus with one transaction outstanding.
// Data has priority, but only for a bounded streak while a fetch is waiting.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [63:0] m_rdata
);

  localparam int unsigned STREAK_W = 3;
  localparam int unsigned SIZE_W   = 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [SIZE_W-1:0]   FETCH_SIZE = SIZE_W'(3'b010);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner_d;
  logic [STREAK_W-1:0] d_streak, d_streak_nxt;
  logic                grant_i, grant_d, done;

  // Next-state, arbitration and streak bookkeeping
  always_comb begin
    state_nxt    = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    done         = 1'b0;
    d_streak_nxt = d_streak;
    case (state)
      IDLE: begin
        if (d_valid && (!i_valid || (d_streak < STREAK_MAX))) begin
          grant_d = 1'b1;
        end else if (i_valid) begin
          grant_i = 1'b1;
        end
        if (grant_i || !i_valid) begin
          d_streak_nxt = '0;
        end else if (grant_d && (d_streak < STREAK_MAX)) begin
          d_streak_nxt = d_streak + STREAK_W'(1);
        end
        if (grant_i || grant_d) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (m_addr_ok) begin
          if (m_data_ok) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (m_data_ok) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Downstream request registers, owner and streak counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d  <= 1'b1;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_size   <= '0;
      m_strobe <= '0;
      m_wdata  <= '0;
      d_streak <= '0;
    end else begin
      d_streak <= d_streak_nxt;
      if (grant_d) begin
        owner_d  <= 1'b1;
        m_valid  <= 1'b1;
        m_addr   <= d_addr;
        m_size   <= d_size;
        m_strobe <= d_strobe;
        m_wdata  <= d_wdata;
      end else if (grant_i) begin
        owner_d  <= 1'b0;
        m_valid  <= 1'b1;
        m_addr   <= i_addr;
        m_size   <= FETCH_SIZE;
        m_strobe <= '0;
        m_wdata  <= '0;
      end else if ((state == REQ) && m_addr_ok) begin
        m_valid  <= 1'b0;
      end
    end
  end

  // A withdrawn requester gets no completion pulse; its response is dropped
  assign d_data_ok = done && owner_d && d_valid;
  assign i_data_ok = done && !owner_d && i_valid;
  assign d_rdata   = d_data_ok ? m_rdata : '0;
  assign i_data    = i_data_ok ? (m_addr[2] ? m_rdata[63:32] : m_rdata[31:0]) : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a queue of expected downstream requests is
// filled as ports request, and drained as the bench-side memory model serves them.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic        is_d;
  } exp_req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [63:0] m_rdata;

  int n_cmp = 0;
  int n_err = 0;
  exp_req_t req_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_i(input logic [63:0] addr);
    req_q.push_back('{addr: addr, size: 3'b010, strobe: 8'h00, wdata: 64'h0, is_d: 1'b0});
  endtask

  task automatic push_d(input logic [63:0] addr, input logic [2:0] size,
                        input logic [7:0] strobe, input logic [63:0] wdata);
    req_q.push_back('{addr: addr, size: size, strobe: strobe, wdata: wdata, is_d: 1'b1});
  endtask

  task automatic check_resp(input exp_req_t e, input logic [63:0] rdata, input bit ok);
    logic [31:0] iw;
    iw = e.addr[2] ? rdata[63:32] : rdata[31:0];
    chk("i_data_ok", i_data_ok, ok && !e.is_d);
    chk("d_data_ok", d_data_ok, ok && e.is_d);
    if (ok && e.is_d)  chk("d_rdata", d_rdata, rdata);
    if (ok && !e.is_d) chk("i_data", 64'(i_data), 64'(iw));
  endtask

  task automatic no_resp(input string tag);
    chk({tag, "_i_ok"}, i_data_ok, 1'b0);
    chk({tag, "_d_ok"}, d_data_ok, 1'b0);
  endtask

  // Memory model: entered in the first REQ cycle, returns in the following IDLE cycle
  task automatic serve(input int a_lat, input int d_lat, input logic [63:0] rdata, input bit ok);
    exp_req_t e;
    chk("grant_m_valid", m_valid, 1'b1);
    n_cmp++;
    assert (req_q.size() != 0) else begin
      n_err++;
      $error("FAIL queue_empty: observed %0d expected >0", req_q.size());
    end
    if (req_q.size() == 0) return;
    e = req_q.pop_front();
    chk("m_addr", m_addr, e.addr);
    chk("m_size", 64'(m_size), 64'(e.size));
    chk("m_strobe", 64'(m_strobe), 64'(e.strobe));
    chk("m_wdata", m_wdata, e.wdata);
    repeat (a_lat) begin
      m_addr_ok = 1'b0;
      step();
      chk("hold_m_valid", m_valid, 1'b1);
      chk("hold_m_addr", m_addr, e.addr);
    end
    m_addr_ok = 1'b1;
    if (d_lat == 0) begin
      m_data_ok = 1'b1;
      m_rdata   = rdata;
    end
    #1;
    if (d_lat == 0) check_resp(e, rdata, ok);
    else            no_resp("addr_phase");
    step();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    if (d_lat > 0) begin
      chk("resp_m_valid", m_valid, 1'b0);
      repeat (d_lat - 1) begin
        #1;
        no_resp("wait");
        step();
      end
      m_data_ok = 1'b1;
      m_rdata   = rdata;
      #1;
      check_resp(e, rdata, ok);
      step();
      m_data_ok = 1'b0;
    end
    if (ok) begin
      if (e.is_d) d_valid = 1'b0;
      else        i_valid = 1'b0;
    end
    chk("idle_m_valid", m_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    step();
    step();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_m_size", 64'(m_size), 64'h0);
    chk("rst_m_strobe", 64'(m_strobe), 64'h0);
    chk("rst_m_wdata", m_wdata, 64'h0);
    chk("rst_i_data", 64'(i_data), 64'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    no_resp("rst");
    reset = 1'b0;
    step();

    // Lone fetch from an odd word: upper half of the response
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    push_i(64'h8000_0004);
    step();
    serve(0, 2, 64'h1111_2222_3333_4444, 1'b1);

    // Collision: D store first, then the waiting fetch
    i_valid = 1'b1; i_addr = 64'h8000_0020;
    d_valid = 1'b1; d_addr = 64'h8000_0100; d_size = 3'b011; d_strobe = 8'hFF;
    d_wdata = 64'hCAFE_F00D_1234_5678;
    push_d(64'h8000_0100, 3'b011, 8'hFF, 64'hCAFE_F00D_1234_5678);
    push_i(64'h8000_0020);
    step();
    serve(0, 1, 64'h0, 1'b1);
    step();
    serve(1, 1, 64'hAAAA_BBBB_9999_8888, 1'b1);

    // Starvation bound: four D reads, forced fetch, then D again
    i_valid = 1'b1; i_addr = 64'h8000_0000;
    d_valid = 1'b1; d_addr = 64'h1000_0040; d_size = 3'b011; d_strobe = 8'h00; d_wdata = 64'h0;
    for (int k = 0; k < 4; k++) push_d(64'h1000_0040, 3'b011, 8'h00, 64'h0);
    push_i(64'h8000_0000);
    push_d(64'h1000_0040, 3'b011, 8'h00, 64'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      serve(0, 1, 64'h5000_0000_0000_0000 + 64'(k), 1'b1);
      if (k < 4) d_valid = 1'b1;
      if (k == 3) chk("streak_sat", 64'(dut.d_streak), 64'd4);
    end
    step();
    chk("streak_clr", 64'(dut.d_streak), 64'd0);
    chk("idle_no_req", m_valid, 1'b0);

    // Combined handshake on a D read
    d_valid = 1'b1; d_addr = 64'h2000_0008; d_size = 3'b011; d_strobe = 8'h00;
    push_d(64'h2000_0008, 3'b011, 8'h00, 64'h0);
    step();
    serve(0, 0, 64'hDEAD_BEEF_0000_0001, 1'b1);
    chk("comb_state_idle", 64'(dut.state), 64'd0);

    // Withdrawal in REQ: request completes downstream, no pulse to the port
    d_valid = 1'b1; d_addr = 64'h3000_0010; d_size = 3'b010; d_strobe = 8'h0F;
    d_wdata = 64'h0000_0000_7777_6666;
    push_d(64'h3000_0010, 3'b010, 8'h0F, 64'h0000_0000_7777_6666);
    step();
    d_valid = 1'b0; d_addr = 64'hFFFF_0000_FFFF_0000;
    serve(2, 1, 64'h1234_1234_1234_1234, 1'b0);
    step();
    chk("wd_no_regrant", m_valid, 1'b0);

    // Reset while a D transaction waits in RESP with a fetch pending
    i_valid = 1'b1; i_addr = 64'h8000_0008;
    d_valid = 1'b1; d_addr = 64'h4000_0000; d_size = 3'b011; d_strobe = 8'h00;
    step();
    chk("pre_rst_m_valid", m_valid, 1'b1);
    chk("pre_rst_streak", 64'(dut.d_streak), 64'd1);
    m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b1; m_rdata = 64'h9999_9999_9999_9999;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_addr", m_addr, 64'h0);
    chk("arst_streak", 64'(dut.d_streak), 64'd0);
    no_resp("arst");
    step();
    m_data_ok = 1'b0;
    reset = 1'b0;
    d_valid = 1'b0;
    i_addr = 64'h8000_000C;
    push_i(64'h8000_000C);
    step();
    serve(0, 1, 64'h0BAD_F00D_600D_CAFE, 1'b1);

    n_cmp++;
    assert (req_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drained: observed %0d expected 0", req_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
